// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer RAM write arbiter: RAM geometry,
// arbiter state encoding and writer source ids.
package la_pkg;

   localparam int LA_ADDR_W = 17;
   localparam int LA_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } arb_state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/la_sync_fifo.sv
// Small synchronous FIFO buffering the non-stallable UART writer.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module la_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 25
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_din,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/la_ram_wr_arbiter.sv
// Shares the sample/config RAM write port between the UART loader (A, buffered)
// and the capture engine (B, valid/ready bursts) with round-robin burst grants.
module la_ram_wr_arbiter
   import la_pkg::*;
#(
   parameter int ADDR_W     = LA_ADDR_W,
   parameter int DATA_W     = LA_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic              clk_50M,
   input  logic              rst_n,
   input  logic              a_wr_en,
   input  logic [ADDR_W-1:0] a_wr_addr,
   input  logic [DATA_W-1:0] a_wr_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_last,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              a_overflow,
   input  logic              ovf_clr,
   output logic              busy,
   output arb_state_t        o_dbg_state
);

   localparam int FIFO_W  = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(MAX_BURST + 1);
   localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

   arb_state_t        r_state;
   logic              r_last_gnt;
   logic [CNT_W-1:0]  r_beat_cnt;

   logic [FIFO_W-1:0] w_fifo_dout;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [FCNT_W-1:0] w_fifo_count;
   logic              w_pop;
   logic              w_b_beat;
   logic              w_at_max;
   logic              w_fifo_drains;

   la_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_a_fifo (
      .clk     (clk_50M),
      .rst_n   (rst_n),
      .i_push  (a_wr_en),
      .i_pop   (w_pop),
      .i_din   ({a_wr_addr, a_wr_data}),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // B handshake: a beat transfers in any cycle where b_valid && b_ready;
   // b_ready is high exactly while B owns the grant, and b_valid low ends the grant.
   assign b_ready       = (r_state == ST_GNT_B);
   assign w_b_beat      = b_ready && b_valid;
   assign w_pop         = (r_state == ST_GNT_A) && !w_fifo_empty;
   assign w_at_max      = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
   assign w_fifo_drains = (w_fifo_count == FCNT_W'(1)) && !a_wr_en;
   assign busy          = (r_state != ST_IDLE) || !w_fifo_empty;
   assign o_dbg_state   = r_state;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= SRC_A;
         r_beat_cnt <= '0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_data   <= '0;
      end else begin
         ram_we <= 1'b0;
         if (w_pop) begin
            ram_we   <= 1'b1;
            ram_addr <= w_fifo_dout[FIFO_W-1:DATA_W];
            ram_data <= w_fifo_dout[DATA_W-1:0];
         end else if (w_b_beat) begin
            ram_we   <= 1'b1;
            ram_addr <= b_addr;
            ram_data <= b_data;
         end

         case (r_state)
            ST_IDLE: begin
               // On contention the source that did not hold the last grant wins.
               if (!w_fifo_empty && (!b_valid || r_last_gnt == SRC_B)) begin
                  r_state    <= ST_GNT_A;
                  r_last_gnt <= SRC_A;
                  r_beat_cnt <= '0;
               end else if (b_valid) begin
                  r_state    <= ST_GNT_B;
                  r_last_gnt <= SRC_B;
                  r_beat_cnt <= '0;
               end
            end
            ST_GNT_A: begin
               if (w_pop) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (w_fifo_drains || w_at_max) r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_GNT_B: begin
               if (b_valid) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (b_last || w_at_max) r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A new drop outranks a simultaneous clear so no overflow event is lost.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         a_overflow <= 1'b0;
      end else if (a_wr_en && w_fifo_full && !w_pop) begin
         a_overflow <= 1'b1;
      end else if (ovf_clr) begin
         a_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_la_ram_wr_arbiter.sv
// Bench for la_ram_wr_arbiter: vector table, directed arbitration sequences and
// random traffic checked every cycle against a queue-based reference model.
module tb_la_ram_wr_arbiter;
   import la_pkg::*;

   localparam int AW    = 17;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int MAXB  = 8;

   logic          clk_50M = 1'b0;
   logic          rst_n   = 1'b0;
   logic          a_wr_en = 1'b0;
   logic [AW-1:0] a_wr_addr = '0;
   logic [DW-1:0] a_wr_data = '0;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic          b_last  = 1'b0;
   logic [AW-1:0] b_addr  = '0;
   logic [DW-1:0] b_data  = '0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          a_overflow;
   logic          ovf_clr = 1'b0;
   logic          busy;
   arb_state_t    dbg_state;

   la_ram_wr_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .FIFO_DEPTH (DEPTH), .MAX_BURST (MAXB)
   ) dut (
      .clk_50M     (clk_50M),
      .rst_n       (rst_n),
      .a_wr_en     (a_wr_en),
      .a_wr_addr   (a_wr_addr),
      .a_wr_data   (a_wr_data),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_last      (b_last),
      .b_addr      (b_addr),
      .b_data      (b_data),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .a_overflow  (a_overflow),
      .ovf_clr     (ovf_clr),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   always #10 clk_50M = ~clk_50M;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the port, a queue for the A buffer, expected outputs.
   localparam int M_IDLE = 0;
   localparam int M_A    = 1;
   localparam int M_B    = 2;
   logic [AW+DW-1:0] m_fifo [$];
   int               m_owner;
   logic             m_last_b;
   int               m_beats;
   logic             m_ovf;
   logic             m_we;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_data;

   task automatic model_reset();
      m_fifo.delete();
      m_owner  = M_IDLE;
      m_last_b = 1'b0;
      m_beats  = 0;
      m_ovf    = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   task automatic model_step();
      bit pop, bbeat, full, drop;
      int want;
      full  = (m_fifo.size() == DEPTH);
      pop   = (m_owner == M_A) && (m_fifo.size() > 0);
      bbeat = (m_owner == M_B) && b_valid;
      m_we  = pop || bbeat;
      if (pop) {m_addr, m_data} = m_fifo[0];
      else if (bbeat) begin
         m_addr = b_addr;
         m_data = b_data;
      end
      if (m_owner == M_IDLE) begin
         want = M_IDLE;
         if (m_fifo.size() > 0 && b_valid) want = m_last_b ? M_A : M_B;
         else if (m_fifo.size() > 0)       want = M_A;
         else if (b_valid)                 want = M_B;
         if (want != M_IDLE) begin
            m_owner  = want;
            m_last_b = (want == M_B);
            m_beats  = 0;
         end
      end else if (m_owner == M_A) begin
         if (pop) begin
            m_beats++;
            if ((m_fifo.size() == 1 && !a_wr_en) || m_beats == MAXB) m_owner = M_IDLE;
         end else m_owner = M_IDLE;
      end else begin
         if (b_valid) begin
            m_beats++;
            if (b_last || m_beats == MAXB) m_owner = M_IDLE;
         end else m_owner = M_IDLE;
      end
      if (pop) void'(m_fifo.pop_front());
      drop = a_wr_en && full && !pop;
      if (a_wr_en && !drop) m_fifo.push_back({a_wr_addr, a_wr_data});
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
   endtask

   task automatic compare_all();
      chk("ram_we", ram_we, m_we);
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_data", ram_data, m_data);
      chk("b_ready", b_ready, m_owner == M_B);
      chk("a_overflow", a_overflow, m_ovf);
      chk("busy", busy, (m_owner != M_IDLE) || (m_fifo.size() > 0));
   endtask

   task automatic tick();
      @(posedge clk_50M);
      model_step();
      @(negedge clk_50M);
      compare_all();
   endtask

   task automatic clear_inputs();
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
      b_valid = 1'b0; b_last = 1'b0; b_addr = '0; b_data = '0;
      ovf_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_50M);
      rst_n = 1'b0;
      clear_inputs();
      #1;
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_b_ready", b_ready, 1'b0);
      chk("rst_ram_addr", ram_addr, 17'h0);
      chk("rst_ram_data", ram_data, 8'h0);
      chk("rst_a_overflow", a_overflow, 1'b0);
      model_reset();
      repeat (2) @(negedge clk_50M);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          a_en;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_data;
      logic          bv;
      logic          bl;
      logic [AW-1:0] bad;
      logic [DW-1:0] bdt;
      logic          e_rdy;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t          vt [17];
   logic [15:0]   tr_rdy;
   logic [15:0]   tr_we;
   int            a_cnt;
   logic [AW-1:0] last_a;
   logic          accepted;

   initial begin
      // single A word, 4-beat B burst, then A word at the top address
      vt[0]  = '{1'b1, 17'h00010, 8'hA5, 1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h0,     8'h0};
      vt[1]  = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h0,     8'h0};
      vt[2]  = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h0,     8'h0};
      vt[3]  = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b1, 17'h00010, 8'hA5};
      vt[4]  = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h00010, 8'hA5};
      vt[5]  = '{1'b0, 17'h0,     8'h0,  1'b1, 1'b0, 17'h100, 8'h30, 1'b0, 1'b0, 17'h00010, 8'hA5};
      vt[6]  = '{1'b0, 17'h0,     8'h0,  1'b1, 1'b0, 17'h100, 8'h30, 1'b1, 1'b0, 17'h00010, 8'hA5};
      vt[7]  = '{1'b0, 17'h0,     8'h0,  1'b1, 1'b0, 17'h101, 8'h31, 1'b1, 1'b1, 17'h00100, 8'h30};
      vt[8]  = '{1'b0, 17'h0,     8'h0,  1'b1, 1'b0, 17'h102, 8'h32, 1'b1, 1'b1, 17'h00101, 8'h31};
      vt[9]  = '{1'b0, 17'h0,     8'h0,  1'b1, 1'b1, 17'h103, 8'h33, 1'b1, 1'b1, 17'h00102, 8'h32};
      vt[10] = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b1, 17'h00103, 8'h33};
      vt[11] = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h00103, 8'h33};
      vt[12] = '{1'b1, 17'h1FFFF, 8'hFF, 1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h00103, 8'h33};
      vt[13] = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h00103, 8'h33};
      vt[14] = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h00103, 8'h33};
      vt[15] = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b1, 17'h1FFFF, 8'hFF};
      vt[16] = '{1'b0, 17'h0,     8'h0,  1'b0, 1'b0, 17'h0,   8'h0,  1'b0, 1'b0, 17'h1FFFF, 8'hFF};

      do_reset();
      for (int i = 0; i < 17; i++) begin
         a_wr_en = vt[i].a_en; a_wr_addr = vt[i].a_addr; a_wr_data = vt[i].a_data;
         b_valid = vt[i].bv;   b_last = vt[i].bl;       b_addr = vt[i].bad; b_data = vt[i].bdt;
         #1;
         chk($sformatf("vec%0d_b_ready", i), b_ready, vt[i].e_rdy);
         chk($sformatf("vec%0d_ram_we", i), ram_we, vt[i].e_we);
         chk($sformatf("vec%0d_ram_addr", i), ram_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_ram_data", i), ram_data, vt[i].e_data);
         tick();
      end
      clear_inputs();

      // Contention after reset: B first (8 beats), idle, A (2 beats), idle, B again.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         tr_rdy[i] = b_ready;
         tr_we[i]  = ram_we;
         a_wr_en   = (i < 2);
         a_wr_addr = AW'(17'h00A00 + i);
         a_wr_data = DW'(8'h50 + i);
         b_valid   = (i >= 1);
         b_last    = 1'b0;
         b_addr    = AW'($urandom());
         b_data    = DW'($urandom());
         tick();
      end
      chk("contention_b_ready_trace", tr_rdy, 16'hC3FC);
      chk("contention_ram_we_trace", tr_we, 16'hB7F8);
      clear_inputs();

      // B holds the port while 5 A words arrive: 4 kept in order, 5th dropped.
      do_reset();
      a_cnt = 0; last_a = '0;
      for (int i = 0; i < 25; i++) begin
         if (ram_we && ram_addr[16:4] == 13'h0A00) begin
            a_cnt++;
            last_a = ram_addr;
         end
         a_wr_en   = (i >= 1 && i <= 5);
         a_wr_addr = AW'(17'h0A000 + i - 1);
         a_wr_data = DW'(i);
         b_valid   = (i <= 5);
         b_addr    = {1'b1, 16'($urandom())};
         b_data    = DW'($urandom());
         tick();
      end
      chk("ovf_sticky", a_overflow, 1'b1);
      chk("ovf_a_write_count", a_cnt, 4);
      chk("ovf_last_a_addr", last_a, 17'h0A003);
      clear_inputs();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", a_overflow, 1'b0);

      // Full FIFO receives a word in the cycle of its first pop: kept, no overflow.
      do_reset();
      a_cnt = 0; last_a = '0;
      for (int i = 0; i < 25; i++) begin
         if (ram_we && ram_addr[16:4] == 13'h0A00) begin
            a_cnt++;
            last_a = ram_addr;
         end
         a_wr_en   = (i >= 1 && i <= 4) || (i == 8);
         a_wr_addr = (i == 8) ? 17'h0A004 : AW'(17'h0A000 + i - 1);
         a_wr_data = DW'(i);
         b_valid   = (i <= 5);
         b_addr    = {1'b1, 16'($urandom())};
         b_data    = DW'($urandom());
         tick();
      end
      chk("fullpop_no_ovf", a_overflow, 1'b0);
      chk("fullpop_a_write_count", a_cnt, 5);
      chk("fullpop_last_a_addr", last_a, 17'h0A004);
      clear_inputs();

      // Reset in the middle of a B burst with A words waiting.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a_wr_en   = (i == 1 || i == 2);
         a_wr_addr = AW'($urandom());
         a_wr_data = DW'($urandom());
         b_valid   = 1'b1;
         b_addr    = AW'($urandom());
         b_data    = DW'($urandom());
         tick();
      end
      chk("midburst_we_before_reset", ram_we, 1'b1);
      chk("midburst_b_ready_before_reset", b_ready, 1'b1);
      do_reset();
      #1;
      chk("midburst_busy_after_reset", busy, 1'b0);
      tick();
      chk("midburst_idle_no_write", ram_we, 1'b0);

      // Random traffic against the model.
      do_reset();
      accepted = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         a_wr_en   = ($urandom_range(0, 2) == 0);
         a_wr_addr = AW'($urandom());
         a_wr_data = DW'($urandom());
         ovf_clr   = ($urandom_range(0, 15) == 0);
         if (!b_valid || accepted) begin
            b_valid = ($urandom_range(0, 1) == 1);
            b_last  = ($urandom_range(0, 3) == 0);
            b_addr  = AW'($urandom());
            b_data  = DW'($urandom());
         end
         #1;
         accepted = b_valid && b_ready;
         tick();
      end
      clear_inputs();
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
